// File: rtl/rocc_multi_acc.sv
// rocc_multi_acc: RoCC accelerator with NUM_ACC accumulators (SET/ADD/READ/LOAD/CLR).
// Define ROCC_ACC_SAT_EN to make ADD/LOAD sums saturate at all-ones instead of wrapping.
module rocc_multi_acc #(
  parameter int xLen             = 64,
  parameter int NUM_ACC          = 4,
  parameter int coreMaxAddrBits  = 40,
  parameter int dcacheReqTagBits = 7,
  parameter int M_SZ             = 5,
  parameter int MEM_TAG          = 0
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        rocc_cmd_valid,
  output logic                        rocc_cmd_ready,
  input  logic [6:0]                  rocc_cmd_bits_inst_funct,
  input  logic [4:0]                  rocc_cmd_bits_inst_rd,
  input  logic                        rocc_cmd_bits_inst_xd,
  input  logic [xLen-1:0]             rocc_cmd_bits_rs1,
  input  logic [xLen-1:0]             rocc_cmd_bits_rs2,
  output logic                        rocc_resp_valid,
  input  logic                        rocc_resp_ready,
  output logic [4:0]                  rocc_resp_bits_rd,
  output logic [xLen-1:0]             rocc_resp_bits_data,
  output logic                        rocc_mem_req_valid,
  input  logic                        rocc_mem_req_ready,
  output logic [coreMaxAddrBits-1:0]  rocc_mem_req_bits_addr,
  output logic [dcacheReqTagBits-1:0] rocc_mem_req_bits_tag,
  output logic [M_SZ-1:0]             rocc_mem_req_bits_cmd,
  output logic [1:0]                  rocc_mem_req_bits_size,
  output logic [xLen-1:0]             rocc_mem_req_bits_data,
  input  logic                        rocc_mem_s2_nack,
  input  logic                        rocc_mem_resp_valid,
  input  logic [dcacheReqTagBits-1:0] rocc_mem_resp_bits_tag,
  input  logic [xLen-1:0]             rocc_mem_resp_bits_data,
  output logic                        rocc_busy,
  output logic                        rocc_interrupt
);
  localparam int IDXW = $clog2(NUM_ACC);
  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] MEM_REQ  = 2'd1;
  localparam logic [1:0] MEM_WAIT = 2'd2;
  localparam logic [1:0] RESP     = 2'd3;
  localparam logic [6:0] F_SET  = 7'd0;
  localparam logic [6:0] F_ADD  = 7'd1;
  localparam logic [6:0] F_READ = 7'd2;
  localparam logic [6:0] F_LOAD = 7'd3;
  localparam logic [6:0] F_CLR  = 7'd4;
  localparam logic [dcacheReqTagBits-1:0] TAG_C  = dcacheReqTagBits'(MEM_TAG);
  localparam logic [1:0]                  SIZE_C = 2'($clog2(xLen / 8));

  function automatic logic [xLen-1:0] acc_add(input logic [xLen-1:0] a, input logic [xLen-1:0] b);
`ifdef ROCC_ACC_SAT_EN
    logic [xLen:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    acc_add = sum[xLen] ? {xLen{1'b1}} : sum[xLen-1:0];
`else
    acc_add = a + b;
`endif
  endfunction

  logic [1:0]                 state_q, state_d;
  logic [xLen-1:0]            acc_q [NUM_ACC];
  logic [xLen-1:0]            acc_d [NUM_ACC];
  logic [coreMaxAddrBits-1:0] addr_q, addr_d;
  logic [4:0]                 rd_q, rd_d;
  logic                       xd_q, xd_d;
  logic [IDXW-1:0]            idx_q, idx_d;
  logic [xLen-1:0]            data_q, data_d;
  logic [IDXW-1:0]            cmd_idx_s;
  logic [xLen-1:0]            cmd_result_s;
  logic [xLen-1:0]            load_sum_s;
  logic                       unused_rs2_hi;

  assign cmd_idx_s     = rocc_cmd_bits_rs2[IDXW-1:0];
  assign unused_rs2_hi = ^rocc_cmd_bits_rs2[xLen-1:IDXW];
  assign load_sum_s    = acc_add(acc_q[idx_q], rocc_mem_resp_bits_data);

  // Next-state, accumulator and captured-field logic
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    addr_d       = addr_q;
    rd_d         = rd_q;
    xd_d         = xd_q;
    idx_d        = idx_q;
    data_d       = data_q;
    cmd_result_s = {xLen{1'b0}};
    case (state_q)
      IDLE: begin
        if (rocc_cmd_valid) begin
          case (rocc_cmd_bits_inst_funct)
            F_SET: begin
              acc_d[cmd_idx_s] = rocc_cmd_bits_rs1;
              cmd_result_s     = rocc_cmd_bits_rs1;
            end
            F_ADD: begin
              cmd_result_s     = acc_add(acc_q[cmd_idx_s], rocc_cmd_bits_rs1);
              acc_d[cmd_idx_s] = cmd_result_s;
            end
            F_READ: cmd_result_s = acc_q[cmd_idx_s];
            F_LOAD: addr_d = rocc_cmd_bits_rs1[coreMaxAddrBits-1:0];
            F_CLR: begin
              for (int k = 0; k < NUM_ACC; k++) begin
                acc_d[k] = {xLen{1'b0}};
              end
            end
            default: cmd_result_s = {xLen{1'b0}};
          endcase
          rd_d  = rocc_cmd_bits_inst_rd;
          xd_d  = rocc_cmd_bits_inst_xd;
          idx_d = cmd_idx_s;
          if (rocc_cmd_bits_inst_funct == F_LOAD) begin
            state_d = MEM_REQ;
          end else if (rocc_cmd_bits_inst_xd) begin
            state_d = RESP;
            data_d  = cmd_result_s;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      MEM_REQ: begin
        if (rocc_mem_req_ready) begin
          state_d = MEM_WAIT;
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_WAIT: begin
        // A nack replays the same address; it wins over a same-cycle response.
        if (rocc_mem_s2_nack) begin
          state_d = MEM_REQ;
        end else if (rocc_mem_resp_valid && (rocc_mem_resp_bits_tag == TAG_C)) begin
          acc_d[idx_q] = load_sum_s;
          data_d       = load_sum_s;
          state_d      = xd_q ? RESP : IDLE;
        end else begin
          state_d = MEM_WAIT;
        end
      end
      RESP: begin
        if (rocc_resp_ready) begin
          state_d = IDLE;
        end else begin
          state_d = RESP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      for (int k = 0; k < NUM_ACC; k++) begin
        acc_q[k] <= {xLen{1'b0}};
      end
      addr_q <= {coreMaxAddrBits{1'b0}};
      rd_q   <= 5'd0;
      xd_q   <= 1'b0;
      idx_q  <= {IDXW{1'b0}};
      data_q <= {xLen{1'b0}};
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      addr_q  <= addr_d;
      rd_q    <= rd_d;
      xd_q    <= xd_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  assign rocc_cmd_ready         = (state_q == IDLE);
  assign rocc_busy              = (state_q != IDLE);
  assign rocc_resp_valid        = (state_q == RESP);
  assign rocc_resp_bits_rd      = rd_q;
  assign rocc_resp_bits_data    = data_q;
  assign rocc_mem_req_valid     = (state_q == MEM_REQ);
  assign rocc_mem_req_bits_addr = addr_q;
  assign rocc_mem_req_bits_tag  = TAG_C;
  assign rocc_mem_req_bits_cmd  = {M_SZ{1'b0}};
  assign rocc_mem_req_bits_size = SIZE_C;
  assign rocc_mem_req_bits_data = {xLen{1'b0}};
  assign rocc_interrupt         = 1'b0;
endmodule

// File: tb/tb_rocc_multi_acc.sv
// Scoreboard bench for rocc_multi_acc: random commands against an array model,
// with a memory responder that can nack, send stray tags and late responses.
module tb_rocc_multi_acc;
  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rocc_cmd_valid = 1'b0;
  logic        rocc_cmd_ready;
  logic [6:0]  rocc_cmd_bits_inst_funct = 7'd0;
  logic [4:0]  rocc_cmd_bits_inst_rd = 5'd0;
  logic        rocc_cmd_bits_inst_xd = 1'b0;
  logic [63:0] rocc_cmd_bits_rs1 = 64'd0;
  logic [63:0] rocc_cmd_bits_rs2 = 64'd0;
  logic        rocc_resp_valid;
  logic        rocc_resp_ready = 1'b1;
  logic [4:0]  rocc_resp_bits_rd;
  logic [63:0] rocc_resp_bits_data;
  logic        rocc_mem_req_valid;
  logic        rocc_mem_req_ready = 1'b1;
  logic [39:0] rocc_mem_req_bits_addr;
  logic [6:0]  rocc_mem_req_bits_tag;
  logic [4:0]  rocc_mem_req_bits_cmd;
  logic [1:0]  rocc_mem_req_bits_size;
  logic [63:0] rocc_mem_req_bits_data;
  logic        rocc_mem_s2_nack = 1'b0;
  logic        rocc_mem_resp_valid = 1'b0;
  logic [6:0]  rocc_mem_resp_bits_tag = 7'd0;
  logic [63:0] rocc_mem_resp_bits_data = 64'd0;
  logic        rocc_busy;
  logic        rocc_interrupt;

  rocc_multi_acc dut (
    .clock(clock), .reset(reset),
    .rocc_cmd_valid(rocc_cmd_valid), .rocc_cmd_ready(rocc_cmd_ready),
    .rocc_cmd_bits_inst_funct(rocc_cmd_bits_inst_funct),
    .rocc_cmd_bits_inst_rd(rocc_cmd_bits_inst_rd),
    .rocc_cmd_bits_inst_xd(rocc_cmd_bits_inst_xd),
    .rocc_cmd_bits_rs1(rocc_cmd_bits_rs1), .rocc_cmd_bits_rs2(rocc_cmd_bits_rs2),
    .rocc_resp_valid(rocc_resp_valid), .rocc_resp_ready(rocc_resp_ready),
    .rocc_resp_bits_rd(rocc_resp_bits_rd), .rocc_resp_bits_data(rocc_resp_bits_data),
    .rocc_mem_req_valid(rocc_mem_req_valid), .rocc_mem_req_ready(rocc_mem_req_ready),
    .rocc_mem_req_bits_addr(rocc_mem_req_bits_addr), .rocc_mem_req_bits_tag(rocc_mem_req_bits_tag),
    .rocc_mem_req_bits_cmd(rocc_mem_req_bits_cmd), .rocc_mem_req_bits_size(rocc_mem_req_bits_size),
    .rocc_mem_req_bits_data(rocc_mem_req_bits_data),
    .rocc_mem_s2_nack(rocc_mem_s2_nack), .rocc_mem_resp_valid(rocc_mem_resp_valid),
    .rocc_mem_resp_bits_tag(rocc_mem_resp_bits_tag), .rocc_mem_resp_bits_data(rocc_mem_resp_bits_data),
    .rocc_busy(rocc_busy), .rocc_interrupt(rocc_interrupt)
  );

  initial forever #5 clock = ~clock;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [63:0] m_acc [4];
  logic [68:0] exp_q [$];
  logic        hold_ready = 1'b0;
  logic        rand_ready = 1'b0;
  logic        responder_en = 1'b1;
  logic        nack_first = 1'b0;
  logic        stray_req = 1'b0;
  logic [39:0] exp_addr = 40'd0;
  int          loads_issued = 0;
  int          loads_done = 0;
  int          req_fires = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic [63:0] madd(input logic [63:0] a, input logic [63:0] b);
`ifdef ROCC_ACC_SAT_EN
    if (b > ~a) return {64{1'b1}};
`endif
    return a + b;
  endfunction

  function automatic logic [63:0] mem_fn(input logic [39:0] a);
    if (a == 40'h1000) return 64'h10;
    return {24'h0, a} * 64'd2654435761 + 64'd17;
  endfunction

  // Issue one command once the accelerator is idle; update the model and scoreboard.
  task automatic do_cmd(input logic [6:0] f, input int idx, input logic [63:0] rs1,
                        input logic [4:0] rd, input logic xd);
    int w;
    logic [63:0] r2;
    logic [63:0] res;
    w = 0;
    @(negedge clock);
    while (!rocc_cmd_ready && w < 300) begin
      @(negedge clock);
      w++;
    end
    if (!rocc_cmd_ready) begin
      chk("cmd_ready_timeout", {63'd0, rocc_cmd_ready}, 64'd1);
      return;
    end
    r2 = {$urandom(), $urandom()};
    r2[1:0] = 2'(idx);
    rocc_cmd_valid = 1'b1;
    rocc_cmd_bits_inst_funct = f;
    rocc_cmd_bits_inst_rd = rd;
    rocc_cmd_bits_inst_xd = xd;
    rocc_cmd_bits_rs1 = rs1;
    rocc_cmd_bits_rs2 = r2;
    res = 64'd0;
    case (f)
      7'd0: begin m_acc[idx] = rs1; res = rs1; end
      7'd1: begin m_acc[idx] = madd(m_acc[idx], rs1); res = m_acc[idx]; end
      7'd2: res = m_acc[idx];
      7'd3: begin
        exp_addr = rs1[39:0];
        loads_issued++;
        m_acc[idx] = madd(m_acc[idx], mem_fn(rs1[39:0]));
        res = m_acc[idx];
      end
      7'd4: for (int k = 0; k < 4; k++) m_acc[k] = 64'd0;
      default: res = 64'd0;
    endcase
    if (xd) exp_q.push_back({rd, res});
    @(posedge clock);
    #1;
    rocc_cmd_valid = 1'b0;
    if (f != 7'd3) chk("resp_latency", {63'd0, rocc_resp_valid}, {63'd0, xd});
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    @(negedge clock);
    while ((exp_q.size() != 0 || !rocc_cmd_ready) && w < 500) begin
      @(negedge clock);
      w++;
    end
    chk("idle_timeout", {63'd0, rocc_cmd_ready}, 64'd1);
  endtask

  // Response ready driver, updated just after the rising edge
  initial forever begin
    @(posedge clock);
    #2;
    if (hold_ready) rocc_resp_ready = 1'b0;
    else if (rand_ready) rocc_resp_ready = 1'($urandom_range(0, 1));
    else rocc_resp_ready = 1'b1;
  end

  // Scoreboard monitor
  initial forever begin
    logic [68:0] e;
    @(negedge clock);
    if (reset && rocc_resp_valid && rocc_resp_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_resp: got rd=%0d data=%h expected none",
                 rocc_resp_bits_rd, rocc_resp_bits_data);
      end else begin
        e = exp_q.pop_front();
        chk("resp_rd", {59'd0, rocc_resp_bits_rd}, {59'd0, e[68:64]});
        chk("resp_data", rocc_resp_bits_data, e[63:0]);
      end
    end
  end

  // Memory responder: optional nack, then a wrong-tag beat, then the real data
  initial forever begin
    @(negedge clock);
    rocc_mem_s2_nack = 1'b0;
    rocc_mem_resp_valid = 1'b0;
    if (stray_req) begin
      rocc_mem_resp_valid = 1'b1;
      rocc_mem_resp_bits_tag = 7'd0;
      rocc_mem_resp_bits_data = 64'hDEAD_BEEF;
      stray_req = 1'b0;
    end else if (responder_en && reset && rocc_mem_req_valid) begin
      req_fires++;
      chk("req_outstanding", {63'd0, loads_issued != loads_done}, 64'd1);
      chk("req_addr", {24'd0, rocc_mem_req_bits_addr}, {24'd0, exp_addr});
      chk("req_fields", {50'd0, rocc_mem_req_bits_tag, rocc_mem_req_bits_cmd, rocc_mem_req_bits_size},
          {50'd0, 7'd0, 5'd0, 2'd3});
      chk("req_data", rocc_mem_req_bits_data, 64'd0);
      @(negedge clock);
      chk("busy_mem_wait", {63'd0, rocc_busy}, 64'd1);
      if (nack_first) begin
        nack_first = 1'b0;
        rocc_mem_s2_nack = 1'b1;
      end else begin
        rocc_mem_resp_valid = 1'b1;
        rocc_mem_resp_bits_tag = 7'd5;
        rocc_mem_resp_bits_data = ~mem_fn(exp_addr);
        @(negedge clock);
        rocc_mem_resp_valid = 1'b1;
        rocc_mem_resp_bits_tag = 7'd0;
        rocc_mem_resp_bits_data = mem_fn(exp_addr);
        loads_done++;
      end
    end
  end

  initial begin
    int f0;
    logic [6:0] f;
    logic [63:0] v;
    for (int k = 0; k < 4; k++) m_acc[k] = 64'd0;
    repeat (2) @(negedge clock);
    chk("rst_cmd_ready", {63'd0, rocc_cmd_ready}, 64'd1);
    chk("rst_resp_valid", {63'd0, rocc_resp_valid}, 64'd0);
    chk("rst_mem_req_valid", {63'd0, rocc_mem_req_valid}, 64'd0);
    chk("rst_busy", {63'd0, rocc_busy}, 64'd0);
    chk("rst_resp_rd", {59'd0, rocc_resp_bits_rd}, 64'd0);
    chk("rst_resp_data", rocc_resp_bits_data, 64'd0);
    chk("interrupt", {63'd0, rocc_interrupt}, 64'd0);
    reset = 1'b1;

    // SET then ADD on accumulator 1
    do_cmd(7'd0, 1, 64'd5, 5'd3, 1'b1);
    do_cmd(7'd1, 1, 64'd7, 5'd9, 1'b1);
    wait_idle();

    // READ held under backpressure for 10 cycles
    do_cmd(7'd0, 2, 64'hCAFE_F00D, 5'd1, 1'b0);
    hold_ready = 1'b1;
    @(posedge clock);
    do_cmd(7'd2, 2, 64'd0, 5'd17, 1'b1);
    begin
      logic ok;
      ok = 1'b1;
      repeat (10) begin
        @(negedge clock);
        if (!rocc_resp_valid || rocc_cmd_ready || rocc_resp_bits_data !== 64'hCAFE_F00D ||
            rocc_resp_bits_rd !== 5'd17) ok = 1'b0;
      end
      chk("resp_hold_stable", {63'd0, ok}, 64'd1);
    end
    hold_ready = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_after_resp", {63'd0, rocc_cmd_ready}, 64'd1);

    // LOAD from 0x1000 onto acc[0]=3, then the same LOAD with a first-attempt nack
    do_cmd(7'd0, 0, 64'd3, 5'd0, 1'b0);
    f0 = req_fires;
    do_cmd(7'd3, 0, 64'h1000, 5'd4, 1'b1);
    wait_idle();
    chk("load_fires", 64'(req_fires - f0), 64'd1);
    f0 = req_fires;
    nack_first = 1'b1;
    do_cmd(7'd3, 0, 64'h1000, 5'd6, 1'b1);
    wait_idle();
    chk("nack_fires", 64'(req_fires - f0), 64'd2);

    // Overflow boundary on acc[3]
    do_cmd(7'd0, 3, {64{1'b1}}, 5'd0, 1'b0);
    do_cmd(7'd1, 3, 64'd2, 5'd8, 1'b1);
    do_cmd(7'd4, 0, 64'd0, 5'd2, 1'b1);
    do_cmd(7'd6, 1, 64'd9, 5'd7, 1'b1);
    wait_idle();

    // Randomized traffic
    rand_ready = 1'b1;
    for (int n = 0; n < 250; n++) begin
      f = 7'($urandom_range(0, 7));
      v = ($urandom_range(0, 3) == 0) ? ~64'($urandom_range(0, 3)) : {$urandom(), $urandom()};
      if (f == 7'd3) nack_first = ($urandom_range(0, 2) == 0);
      do_cmd(f, $urandom_range(0, 3), v, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    rand_ready = 1'b0;

    // Reset while waiting on memory, then a late response
    responder_en = 1'b0;
    do_cmd(7'd3, 1, 64'h2000, 5'd5, 1'b0);
    @(posedge clock);
    #1;
    chk("busy_before_rst", {63'd0, rocc_busy}, 64'd1);
    chk("req_low_in_wait", {63'd0, rocc_mem_req_valid}, 64'd0);
    reset = 1'b0;
    #1;
    chk("mid_rst_cmd_ready", {63'd0, rocc_cmd_ready}, 64'd1);
    chk("mid_rst_busy", {63'd0, rocc_busy}, 64'd0);
    chk("mid_rst_mem_req", {63'd0, rocc_mem_req_valid}, 64'd0);
    chk("mid_rst_resp_valid", {63'd0, rocc_resp_valid}, 64'd0);
    chk("mid_rst_rd", {59'd0, rocc_resp_bits_rd}, 64'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    for (int k = 0; k < 4; k++) m_acc[k] = 64'd0;
    loads_issued = loads_done;
    stray_req = 1'b1;
    repeat (3) @(negedge clock);
    chk("post_rst_cmd_ready", {63'd0, rocc_cmd_ready}, 64'd1);
    chk("post_rst_busy", {63'd0, rocc_busy}, 64'd0);
    chk("post_rst_resp_valid", {63'd0, rocc_resp_valid}, 64'd0);
    responder_en = 1'b1;
    for (int k = 0; k < 4; k++) do_cmd(7'd2, k, 64'd0, 5'(k + 20), 1'b1);
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
